alarm_trigger: RTL and testbench
================================

# alarm_trigger

Initiator side of the LED reminder interface: watches the running BCD time, holds the user-set alarm time, and generates the chime and alarm requests that the reminder block turns into light patterns. It produces the hourly chime pulse and blink count, and the alarm start pulse and ring-active level. It also runs a ring/snooze state machine. It sits between the time-of-day counter and the reminder, on the same 1 Hz clock.

## Interface
Parameters:
- RING_SECS, 31, cycles `active_alarm` stays high per ring; matches the reminder's 31-step pattern.
- SNOOZE_SECS, 300, cycles spent in SNOOZE before re-ringing.
- ALARM_HOUR_INIT, 8'h07, BCD alarm hour after reset.
- ALARM_MIN_INIT, 8'h00, BCD alarm minute after reset.

Ports:
- CP_1Hz  in  1  sole clock; all state updates on rising edge.
- _CR  in  1  asynchronous, active-low reset.
- hour  in  8  current hour, BCD 00–23.
- minute  in  8  current minute, BCD 00–59.
- second  in  8  current second, BCD 00–59.
- chime_en  in  1  enables the hourly chime.
- alarm_en  in  1  arms the alarm.
- set_mode  in  1  alarm-time edit mode.
- adj_hour  in  1  in set_mode: alarm hour +1 per cycle while held.
- adj_min  in  1  in set_mode: alarm minute +1 per cycle while held.
- stop  in  1  cancels a ring or snooze.
- snooze  in  1  defers a ring by SNOOZE_SECS.
- start_light_hour  out  1  one-cycle chime request.
- show_hour  out  8  chime blink count, 1–12, binary.
- start_light_alarm  out  1  one-cycle ring-start request.
- active_alarm  out  1  high while RINGING.
- alarm_hour  out  8  BCD alarm hour, for display.
- alarm_min  out  8  BCD alarm minute, for display.

## Operation
- Reset values:
  - start_light_hour=0, start_light_alarm=0, active_alarm=0.
  - show_hour=12.
  - alarm_hour=ALARM_HOUR_INIT, alarm_min=ALARM_MIN_INIT.
  - State=IDLE; ring and snooze counters=0.
- Chime:
  - Condition: chime_en & minute==00 & second==00.
  - Response: start_light_hour=1 for one cycle.
  - show_hour is loaded with the 12-hour value on the same edge: 00→12, 01–12 unchanged, 13–23→h−12.
  - show_hour holds until the next chime.
- Alarm match: hour==alarm_hour & minute==alarm_min & second==00 & alarm_en & !set_mode.
- States:
  - IDLE → RINGING on match. start_light_alarm pulses 1 cycle, active_alarm=1, ring counter cleared.
  - RINGING:
    - ring counter +1 per cycle; after RING_SECS cycles high → IDLE.
    - stop → IDLE; stop has priority over snooze.
    - snooze → SNOOZE with snooze counter cleared.
  - SNOOZE: counter +1 per cycle; at SNOOZE_SECS → RINGING with a fresh start_light_alarm pulse; stop → IDLE.
  - Any state, !alarm_en or set_mode → IDLE next edge; active_alarm=0.
- Alarm edit:
  - Only in set_mode.
  - Hour wraps 23→00; minute wraps 59→00 with no carry into hour.
  - adj_hour and adj_min together: both increment.
- Simultaneous chime and alarm at HH:00:00: both pulses are asserted on the same cycle.
- A match while already RINGING or SNOOZE is ignored; there is no restart.

## Timing
- Inputs are sampled at edge N; outputs are registered and visible after edge N, giving one-cycle latency.
- The reminder samples the pulses at edge N+1.
- Pulses are exactly one cycle wide; active_alarm rises together with start_light_alarm.
- active_alarm is high for exactly RING_SECS cycles unless stop, snooze, !alarm_en or set_mode intervenes. It falls on the edge after that input is sampled.
- The snoozed re-ring pulse comes SNOOZE_SECS cycles after the SNOOZE entry edge.
- Reset asserted mid-ring: all outputs go to reset values immediately, without waiting for an edge.

## Structure
- Shared package clock_pkg:
  - State enum IDLE/RINGING/SNOOZE.
  - BCD limit constants 8'h23 and 8'h59.
  - BCD-to-12-hour conversion function.
- Sub-module bcd_mod_counter (parameter MAX), a BCD increment-with-wrap register, instantiated for alarm_hour (MAX 8'h23) and alarm_min (MAX 8'h59).

## Test plan
- Reset, then time 14:00:00 with chime_en=1 → start_light_hour pulses 1 cycle; show_hour=2. At 00:00:00 → show_hour=12.
- Alarm 07:00, alarm_en=1, time 07:00:00 → start_light_alarm pulses 1 cycle; active_alarm high exactly 31 cycles, then 0.
- Ringing, snooze asserted at cycle 5 → active_alarm falls next edge. After 300 cycles → new pulse and a fresh 31-cycle ring. stop during SNOOZE → no re-ring.
- Edit mode: set_mode=1, adj_min held 3 cycles from 58 → 59, 00, 01, hour unchanged. adj_hour from 23 → 00. A match with set_mode=1 produces no pulse.
- Alarm 09:00, time 09:00:00, chime_en=1 → both pulses on the same cycle; show_hour=9.
- stop and snooze together while ringing → IDLE; drop alarm_en mid-ring → active_alarm 0 next edge. _CR low mid-ring → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared alarm state type, BCD limits and 12-hour conversion
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

  // BCD 00-23 hour to binary 1-12 blink count (midnight blinks 12 times)
  function automatic logic [7:0] bcd_to_12h(input logic [7:0] bcd_hour);
    logic [7:0] bin;
    bin = ({4'd0, bcd_hour[7:4]} * 8'd10) + {4'd0, bcd_hour[3:0]};
    if (bin == 8'd0) begin
      return 8'd12;
    end else if (bin > 8'd12) begin
      return bin - 8'd12;
    end
    return bin;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD register that increments and wraps at MAX
module bcd_mod_counter #(
  parameter logic [7:0] MAX  = 8'h59,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value
);

  // Step once per enabled cycle; units roll into tens, MAX rolls to 00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (inc) begin
      if (value == MAX) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - hourly chime and alarm ring/snooze request generator
module alarm_trigger
  import clock_pkg::*;
#(
  parameter int         RING_SECS       = 31,
  parameter int         SNOOZE_SECS     = 300,
  parameter logic [7:0] ALARM_HOUR_INIT = 8'h07,
  parameter logic [7:0] ALARM_MIN_INIT  = 8'h00
) (
  input  logic       CP_1Hz,
  input  logic       _CR,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       adj_hour,
  input  logic       adj_min,
  input  logic       stop,
  input  logic       snooze,
  output logic       start_light_hour,
  output logic [7:0] show_hour,
  output logic       start_light_alarm,
  output logic       active_alarm,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min
);

  localparam int RING_W   = $clog2(RING_SECS + 1);
  localparam int SNOOZE_W = $clog2(SNOOZE_SECS + 1);
  localparam logic [RING_W-1:0]   RING_LAST   = RING_W'(RING_SECS - 1);
  localparam logic [SNOOZE_W-1:0] SNOOZE_LAST = SNOOZE_W'(SNOOZE_SECS - 1);

  alarm_state_t          state;
  logic [RING_W-1:0]     ring_cnt;
  logic [SNOOZE_W-1:0]   snooze_cnt;
  logic                  top_of_hour;
  logic                  chime_hit;
  logic                  alarm_match;

  assign top_of_hour = (minute == 8'h00) && (second == 8'h00);
  assign chime_hit   = chime_en && top_of_hour;
  assign alarm_match = (hour == alarm_hour) && (minute == alarm_min) &&
                       (second == 8'h00) && alarm_en && !set_mode;

  bcd_mod_counter #(
    .MAX  (BCD_HOUR_MAX),
    .INIT (ALARM_HOUR_INIT)
  ) u_alarm_hour (
    .clk   (CP_1Hz),
    .rst_n (_CR),
    .inc   (set_mode && adj_hour),
    .value (alarm_hour)
  );

  bcd_mod_counter #(
    .MAX  (BCD_MIN_MAX),
    .INIT (ALARM_MIN_INIT)
  ) u_alarm_min (
    .clk   (CP_1Hz),
    .rst_n (_CR),
    .inc   (set_mode && adj_min),
    .value (alarm_min)
  );

  // Hourly chime: one-cycle request plus a blink count held until the next chime
  always_ff @(posedge CP_1Hz or negedge _CR) begin
    if (!_CR) begin
      start_light_hour <= 1'b0;
      show_hour        <= 8'd12;
    end else begin
      start_light_hour <= chime_hit;
      if (chime_hit) begin
        show_hour <= bcd_to_12h(hour);
      end
    end
  end

  // Ring/snooze sequencer; disarming or editing always wins and parks in IDLE
  always_ff @(posedge CP_1Hz or negedge _CR) begin
    if (!_CR) begin
      state             <= IDLE;
      ring_cnt          <= '0;
      snooze_cnt        <= '0;
      start_light_alarm <= 1'b0;
      active_alarm      <= 1'b0;
    end else begin
      start_light_alarm <= 1'b0;
      if (!alarm_en || set_mode) begin
        state        <= IDLE;
        active_alarm <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (alarm_match) begin
              state             <= RINGING;
              start_light_alarm <= 1'b1;
              active_alarm      <= 1'b1;
              ring_cnt          <= '0;
            end
          end
          RINGING: begin
            if (stop) begin
              state        <= IDLE;
              active_alarm <= 1'b0;
            end else if (snooze) begin
              state        <= SNOOZE;
              active_alarm <= 1'b0;
              snooze_cnt   <= '0;
            end else if (ring_cnt == RING_LAST) begin
              state        <= IDLE;
              active_alarm <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RING_W'(1);
            end
          end
          SNOOZE: begin
            if (stop) begin
              state <= IDLE;
            end else if (snooze_cnt == SNOOZE_LAST) begin
              state             <= RINGING;
              start_light_alarm <= 1'b1;
              active_alarm      <= 1'b1;
              ring_cnt          <= '0;
            end else begin
              snooze_cnt <= snooze_cnt + SNOOZE_W'(1);
            end
          end
          default: begin
            state        <= IDLE;
            active_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - scoreboard bench for alarm_trigger
module tb_alarm_trigger;

  logic       clk;
  logic       rst_n;
  logic [7:0] hour, minute, second;
  logic       chime_en, alarm_en, set_mode, adj_hour, adj_min, stop, snooze;
  logic       start_light_hour, start_light_alarm, active_alarm;
  logic [7:0] show_hour, alarm_hour, alarm_min;

  alarm_trigger dut (
    .CP_1Hz            (clk),
    ._CR               (rst_n),
    .hour              (hour),
    .minute            (minute),
    .second            (second),
    .chime_en          (chime_en),
    .alarm_en          (alarm_en),
    .set_mode          (set_mode),
    .adj_hour          (adj_hour),
    .adj_min           (adj_min),
    .stop              (stop),
    .snooze            (snooze),
    .start_light_hour  (start_light_hour),
    .show_hour         (show_hour),
    .start_light_alarm (start_light_alarm),
    .active_alarm      (active_alarm),
    .alarm_hour        (alarm_hour),
    .alarm_min         (alarm_min)
  );

  typedef struct {
    logic       lh;
    logic       la;
    logic [7:0] sh;
    int         cyc;
  } pulse_t;

  pulse_t exp_q[$];
  int     len_q[$];
  int     cyc;
  int     n_checks;
  int     n_pass;
  bit     done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned actual, input int unsigned expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour = h;
    minute = m;
    second = s;
  endtask

  task automatic expect_pulse(input logic lh, input logic la, input logic [7:0] sh, input int delay);
    pulse_t p;
    p.lh  = lh;
    p.la  = la;
    p.sh  = sh;
    p.cyc = cyc + delay;
    exp_q.push_back(p);
  endtask

  // Monitor: pops an expected pulse whenever the DUT raises one, and times each ring
  initial begin
    int run;
    pulse_t e;
    run = 0;
    while (!done) begin
      @(negedge clk);
      if (start_light_hour || start_light_alarm) begin
        check("pulse_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_hour", start_light_hour, e.lh);
          check("pulse_alarm", start_light_alarm, e.la);
          check("pulse_cycle", cyc, e.cyc);
          if (e.lh) check("show_hour", show_hour, e.sh);
        end
      end
      if (active_alarm) begin
        run++;
      end else if (run > 0) begin
        check("ring_expected", (len_q.size() != 0), 1);
        if (len_q.size() != 0) check("ring_len", run, len_q.pop_front());
        run = 0;
      end
    end
  end

  logic [7:0] chime_h[6]  = '{8'h14, 8'h00, 8'h12, 8'h13, 8'h01, 8'h23};
  logic [7:0] chime_sh[6] = '{8'd2, 8'd12, 8'd12, 8'd1, 8'd1, 8'd11};
  logic [7:0] min_seq[3]  = '{8'h59, 8'h00, 8'h01};

  initial begin
    cyc = 0;
    n_checks = 0;
    n_pass = 0;
    done = 1'b0;
    rst_n = 1'b0;
    set_time(8'h00, 8'h00, 8'h01);
    {chime_en, alarm_en, set_mode, adj_hour, adj_min, stop, snooze} = '0;
    #12;
    check("rst_start_light_hour", start_light_hour, 0);
    check("rst_start_light_alarm", start_light_alarm, 0);
    check("rst_active_alarm", active_alarm, 0);
    check("rst_show_hour", show_hour, 12);
    check("rst_alarm_hour", alarm_hour, 8'h07);
    check("rst_alarm_min", alarm_min, 8'h00);
    tick();
    rst_n = 1'b1;
    tick(2);

    // Chime table
    chime_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_time(chime_h[i], 8'h00, 8'h00);
      expect_pulse(1'b1, 1'b0, chime_sh[i], 1);
      tick();
      second = 8'h01;
      tick(3);
      check("show_hour_hold", show_hour, chime_sh[i]);
    end
    chime_en = 1'b0;
    set_time(8'h15, 8'h00, 8'h00);
    tick();
    second = 8'h01;
    tick(2);
    check("show_hour_no_chime", show_hour, 11);

    // Full ring, with a repeated match mid-ring that must be ignored
    alarm_en = 1'b1;
    set_time(8'h07, 8'h00, 8'h00);
    expect_pulse(1'b0, 1'b1, 8'd0, 1);
    len_q.push_back(31);
    tick();
    second = 8'h01;
    tick(9);
    second = 8'h00;
    tick();
    second = 8'h01;
    tick(35);
    check("ring_done_active", active_alarm, 0);

    // Snooze after 5 ring cycles, re-ring 300 cycles after snooze entry
    second = 8'h00;
    expect_pulse(1'b0, 1'b1, 8'd0, 1);
    len_q.push_back(5);
    tick();
    second = 8'h01;
    tick(4);
    snooze = 1'b1;
    expect_pulse(1'b0, 1'b1, 8'd0, 301);
    len_q.push_back(31);
    tick();
    snooze = 1'b0;
    check("snooze_active", active_alarm, 0);
    tick(340);

    // Snooze then stop: no re-ring
    second = 8'h00;
    expect_pulse(1'b0, 1'b1, 8'd0, 1);
    len_q.push_back(1);
    tick();
    second = 8'h01;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    tick(10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(320);

    // Alarm-time edit
    set_mode = 1'b1;
    adj_min = 1'b1;
    tick(58);
    check("edit_min_58", alarm_min, 8'h58);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("edit_min_wrap", alarm_min, min_seq[i]);
    end
    check("edit_min_no_carry", alarm_hour, 8'h07);
    adj_min = 1'b0;
    adj_hour = 1'b1;
    tick(16);
    check("edit_hour_23", alarm_hour, 8'h23);
    tick();
    check("edit_hour_wrap", alarm_hour, 8'h00);
    adj_min = 1'b1;
    tick();
    check("edit_both_hour", alarm_hour, 8'h01);
    check("edit_both_min", alarm_min, 8'h02);
    adj_hour = 1'b0;
    adj_min = 1'b0;
    set_time(8'h01, 8'h02, 8'h00);
    tick();
    second = 8'h01;
    tick(2);
    check("set_mode_no_ring", active_alarm, 0);

    // Move alarm to 09:00
    adj_hour = 1'b1;
    tick(8);
    adj_hour = 1'b0;
    adj_min = 1'b1;
    tick(58);
    adj_min = 1'b0;
    set_mode = 1'b0;
    check("alarm_0900_hour", alarm_hour, 8'h09);
    check("alarm_0900_min", alarm_min, 8'h00);

    // Chime and alarm together, then stop+snooze together
    chime_en = 1'b1;
    set_time(8'h09, 8'h00, 8'h00);
    expect_pulse(1'b1, 1'b1, 8'd9, 1);
    len_q.push_back(3);
    tick();
    second = 8'h01;
    tick(2);
    stop = 1'b1;
    snooze = 1'b1;
    tick();
    stop = 1'b0;
    snooze = 1'b0;
    tick(310);

    // Disarm mid-ring
    chime_en = 1'b0;
    second = 8'h00;
    expect_pulse(1'b0, 1'b1, 8'd0, 1);
    len_q.push_back(2);
    tick();
    second = 8'h01;
    tick();
    alarm_en = 1'b0;
    tick();
    check("disarm_active", active_alarm, 0);
    alarm_en = 1'b1;
    tick(3);

    // Asynchronous reset mid-ring
    second = 8'h00;
    expect_pulse(1'b0, 1'b1, 8'd0, 1);
    len_q.push_back(2);
    tick();
    second = 8'h01;
    tick(2);
    check("pre_rst_active", active_alarm, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_active_alarm", active_alarm, 0);
    check("arst_start_light_alarm", start_light_alarm, 0);
    check("arst_start_light_hour", start_light_hour, 0);
    check("arst_show_hour", show_hour, 12);
    check("arst_alarm_hour", alarm_hour, 8'h07);
    check("arst_alarm_min", alarm_min, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    check("pulses_outstanding", exp_q.size(), 0);
    check("rings_outstanding", len_q.size(), 0);
    done = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
